// File: rtl/fila_de_instrucoes_param.sv
// -----------------------------------------------------------------------------
// fila_de_instrucoes_param
//
// Parametrised in-order instruction queue between fetch and the R/I issue
// stations. Each accepted instruction is tagged with its class (R or I) using
// the opcode-to-class masks and is dispatched strictly in arrival order.
// Dispatch is either unconditional (Pop) or filtered by the head's class
// (Pop_R / Pop_I). Words with an unmapped opcode are consumed without being
// stored, and Illegal pulses for one cycle.
//
// Ports:
//   Clock, Reset         single clock, synchronous active-high reset
//   Flush                empties the queue at the next edge
//   Push_Valid/Instr     valid/ready push port from fetch
//   Push_Ready           combinational accept (pre-edge state, never uses Pop)
//   Pop, Pop_R, Pop_I    dispatch requests (any class / R only / I only)
//   Instrucao_Despachada registered dispatched word (NOP when idle)
//   Despacho_Valid       registered, high for one cycle per real dispatch
//   Tipo_Despachado      registered class of the dispatch (0 = R, 1 = I)
//   Head_Tipo            class of the current head (0 when empty)
//   Illegal              registered pulse for an accepted unmapped opcode
//   Count/Count_R/Count_I total and per-class occupancy
//   Full, Empty          occupancy flags derived from Count
// -----------------------------------------------------------------------------
module fila_de_instrucoes_param #(
  parameter int               WIDTH   = 16,
  parameter int               DEPTH   = 16,
  parameter int               OPC_MSB = 15,
  parameter logic [7:0]       R_MASK  = 8'b0000_1100,
  parameter logic [7:0]       I_MASK  = 8'b0011_0000,
  parameter int               MAX_R   = DEPTH,
  parameter int               MAX_I   = DEPTH,
  parameter logic [WIDTH-1:0] NOP     = WIDTH'(16'h0005)
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic                     Push_Valid,
  input  logic [WIDTH-1:0]         Push_Instr,
  output logic                     Push_Ready,
  input  logic                     Pop,
  input  logic                     Pop_R,
  input  logic                     Pop_I,
  output logic [WIDTH-1:0]         Instrucao_Despachada,
  output logic                     Despacho_Valid,
  output logic                     Tipo_Despachado,
  output logic                     Head_Tipo,
  output logic                     Illegal,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [$clog2(DEPTH):0]   Count_R,
  output logic [$clog2(DEPTH):0]   Count_I,
  output logic                     Full,
  output logic                     Empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Caps larger than the queue can never bind, so clamp them to DEPTH to
  // keep the comparisons within the counter width.
  localparam int MAX_R_CL = (MAX_R > DEPTH) ? DEPTH : MAX_R;
  localparam int MAX_I_CL = (MAX_I > DEPTH) ? DEPTH : MAX_I;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_R_C = CW'(MAX_R_CL);
  localparam logic [CW-1:0] MAX_I_C = CW'(MAX_I_CL);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Each entry is {class bit, instruction}; class 0 = R, 1 = I.
  logic [WIDTH:0]   mem_q [DEPTH];

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    count_r_q, count_r_d;
  logic [CW-1:0]    count_i_q, count_i_d;
  logic [WIDTH-1:0] desp_q, desp_d;
  logic             valid_q, valid_d;
  logic             tipo_q, tipo_d;
  logic             illegal_q, illegal_d;

  logic [2:0]       opc;
  logic             is_r;
  logic             is_i;
  logic             is_illegal;
  logic             full;
  logic             empty;
  logic             class_room;
  logic             push_ready;
  logic             push_fire;
  logic             store;
  logic [WIDTH:0]   head_entry;
  logic             head_cls;
  logic             pop_fire;

  assign opc        = Push_Instr[OPC_MSB -: 3];
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == CNT_ZERO);
  assign head_entry = mem_q[head_q];
  assign head_cls   = head_entry[WIDTH];

  // Opcode classification and push acceptance, all from pre-edge state.
  always_comb begin
    is_r       = R_MASK[opc];
    // R wins if a mis-configured pair of masks overlaps.
    is_i       = (!R_MASK[opc]) && I_MASK[opc];
    is_illegal = !(R_MASK[opc] || I_MASK[opc]);
    if (is_r) begin
      class_room = (count_r_q < MAX_R_C);
    end else if (is_i) begin
      class_room = (count_i_q < MAX_I_C);
    end else begin
      class_room = 1'b1;
    end
    if (Reset || Flush) begin
      push_ready = 1'b0;
    end else if (is_illegal) begin
      // Unmapped words are always swallowed; they never occupy an entry.
      push_ready = 1'b1;
    end else begin
      push_ready = (!full) && class_room;
    end
    push_fire = Push_Valid && push_ready;
    store     = push_fire && !is_illegal;
  end

  // Dispatch select on the current head; Reset/Flush suppress any dispatch.
  always_comb begin
    if (Reset || Flush) begin
      pop_fire = 1'b0;
    end else if (empty) begin
      pop_fire = 1'b0;
    end else if (Pop) begin
      pop_fire = 1'b1;
    end else if (Pop_R && !head_cls) begin
      pop_fire = 1'b1;
    end else if (Pop_I && head_cls) begin
      pop_fire = 1'b1;
    end else begin
      pop_fire = 1'b0;
    end
  end

  // Next-state for pointers, counters and the registered dispatch outputs.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    count_r_d = count_r_q;
    count_i_d = count_i_q;
    desp_d    = NOP;
    valid_d   = 1'b0;
    tipo_d    = 1'b0;
    illegal_d = 1'b0;
    if (Reset || Flush) begin
      head_d    = PTR_ZERO;
      tail_d    = PTR_ZERO;
      count_d   = CNT_ZERO;
      count_r_d = CNT_ZERO;
      count_i_d = CNT_ZERO;
    end else begin
      if (store) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_fire) begin
        head_d  = head_q + PTR_ONE;
        desp_d  = head_entry[WIDTH-1:0];
        valid_d = 1'b1;
        tipo_d  = head_cls;
      end else begin
        head_d  = head_q;
      end
      // Push and pop move the class counters independently.
      count_d   = count_q + CW'(store) - CW'(pop_fire);
      count_r_d = count_r_q + CW'(store && is_r) - CW'(pop_fire && !head_cls);
      count_i_d = count_i_q + CW'(store && is_i) - CW'(pop_fire && head_cls);
      illegal_d = push_fire && is_illegal;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      head_q    <= PTR_ZERO;
      tail_q    <= PTR_ZERO;
      count_q   <= CNT_ZERO;
      count_r_q <= CNT_ZERO;
      count_i_q <= CNT_ZERO;
      desp_q    <= NOP;
      valid_q   <= 1'b0;
      tipo_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      count_r_q <= count_r_d;
      count_i_q <= count_i_d;
      desp_q    <= desp_d;
      valid_q   <= valid_d;
      tipo_q    <= tipo_d;
      illegal_q <= illegal_d;
    end
  end

  // Entry storage; contents are don't-care after Reset or Flush.
  always_ff @(posedge Clock) begin
    if (store) begin
      mem_q[tail_q] <= {is_i, Push_Instr};
    end
  end

  assign Push_Ready           = push_ready;
  assign Instrucao_Despachada = desp_q;
  assign Despacho_Valid       = valid_q;
  assign Tipo_Despachado      = tipo_q;
  assign Head_Tipo            = (!empty) && head_cls;
  assign Illegal              = illegal_q;
  assign Count                = count_q;
  assign Count_R              = count_r_q;
  assign Count_I              = count_i_q;
  assign Full                 = full;
  assign Empty                = empty;

endmodule

// File: tb/tb_fila_de_instrucoes_param.sv
// Bench for fila_de_instrucoes_param (DEPTH=4, MAX_R=2, MAX_I=3). A queue
// based reference model predicts every output; a vector table and short
// hand-written sequences pin the documented scenarios to fixed values.
module tb_fila_de_instrucoes_param;
  localparam int D = 4;
  localparam logic [15:0] NOPV = 16'h0005;

  logic        clk = 1'b0;
  logic        rst = 1'b0, flush = 1'b0, pv = 1'b0, pop = 1'b0, popr = 1'b0, popi = 1'b0;
  logic [15:0] pi = 16'h0000;
  logic [15:0] desp;
  logic        dv, tipo, htipo, ill, ready, full, empty;
  logic [2:0]  cnt, cnt_r, cnt_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fila_de_instrucoes_param #(
    .WIDTH(16), .DEPTH(D), .OPC_MSB(15),
    .R_MASK(8'b0000_1100), .I_MASK(8'b0011_0000),
    .MAX_R(2), .MAX_I(3), .NOP(16'h0005)
  ) dut (
    .Clock(clk), .Reset(rst), .Flush(flush),
    .Push_Valid(pv), .Push_Instr(pi), .Push_Ready(ready),
    .Pop(pop), .Pop_R(popr), .Pop_I(popi),
    .Instrucao_Despachada(desp), .Despacho_Valid(dv), .Tipo_Despachado(tipo),
    .Head_Tipo(htipo), .Illegal(ill),
    .Count(cnt), .Count_R(cnt_r), .Count_I(cnt_i),
    .Full(full), .Empty(empty)
  );

  // Reference model: queue of {class, instruction}
  logic [16:0] mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // 0 = R, 1 = I, 2 = unmapped
  function automatic int cls_of(input logic [15:0] ins);
    case (ins[15:13])
      3'd2, 3'd3: return 0;
      3'd4, 3'd5: return 1;
      default:    return 2;
    endcase
  endfunction

  function automatic int n_class(input int c);
    int n = 0;
    foreach (mq[k]) if (int'(mq[k][16]) == c) n++;
    return n;
  endfunction

  // One clock cycle: drive, check Push_Ready, advance model, check outputs.
  task automatic apply(input logic r, input logic f, input logic v, input logic [15:0] ins,
                       input logic p, input logic pr, input logic pq, output logic obs_ready);
    int          c;
    logic        er, disp;
    logic [16:0] hd;
    logic [15:0] e_desp;
    logic        e_dv, e_tipo, e_ill;
    @(negedge clk);
    rst = r; flush = f; pv = v; pi = ins; pop = p; popr = pr; popi = pq;
    #1;
    c = cls_of(ins);
    if (r || f)              er = 1'b0;
    else if (c == 2)         er = 1'b1;
    else if (mq.size() == D) er = 1'b0;
    else if (c == 0)         er = (n_class(0) < 2);
    else                     er = (n_class(1) < 3);
    obs_ready = ready;
    chk("push_ready", {31'd0, ready}, {31'd0, er});
    e_desp = NOPV; e_dv = 1'b0; e_tipo = 1'b0; e_ill = 1'b0;
    if (r || f) begin
      mq.delete();
    end else begin
      disp = (mq.size() > 0) && (p || (pr && mq[0][16] == 1'b0) || (pq && mq[0][16] == 1'b1));
      if (disp) begin
        hd = mq.pop_front();
        e_desp = hd[15:0]; e_dv = 1'b1; e_tipo = hd[16];
      end
      e_ill = v && er && (c == 2);
      if (v && er && c != 2) mq.push_back({(c == 1), ins});
    end
    @(posedge clk);
    #1;
    chk("dispatch_data", {16'd0, desp}, {16'd0, e_desp});
    chk("dispatch_valid", {31'd0, dv}, {31'd0, e_dv});
    chk("dispatch_tipo", {31'd0, tipo}, {31'd0, e_tipo});
    chk("illegal", {31'd0, ill}, {31'd0, e_ill});
    chk("count", {29'd0, cnt}, mq.size());
    chk("count_r", {29'd0, cnt_r}, n_class(0));
    chk("count_i", {29'd0, cnt_i}, n_class(1));
    chk("empty", {31'd0, empty}, (mq.size() == 0) ? 1 : 0);
    chk("full", {31'd0, full}, (mq.size() == D) ? 1 : 0);
    chk("head_tipo", {31'd0, htipo}, (mq.size() > 0) ? {31'd0, mq[0][16]} : 0);
  endtask

  typedef struct {
    logic        v;
    logic [15:0] ins;
    logic        p, pr, pq;
    logic        e_ready;
    logic [15:0] e_desp;
    logic        e_dv, e_tipo;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic        rd;
    logic [15:0] ins;

    // ADD=4011 LD=8022 SUB=6033 ST=A044; instruction 0000 is unmapped (ready=1)
    tbl.push_back('{1'b1, 16'h4011, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b1, 16'h8022, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 2});
    tbl.push_back('{1'b1, 16'h6033, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 3});
    tbl.push_back('{1'b1, 16'hA044, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 4});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4011, 1'b1, 1'b0, 3});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8022, 1'b1, 1'b1, 2});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h6033, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA044, 1'b1, 1'b1, 0});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 0});
    // Head LD: Pop_R must not dispatch, Pop_I must
    tbl.push_back('{1'b1, 16'h8022, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b1, 16'h4011, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 2});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 2});
    tbl.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8022, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4011, 1'b1, 1'b0, 0});

    // Reset for two cycles; Push_Ready must be low while Reset is high
    apply(1'b1, 1'b0, 1'b1, 16'h4011, 1'b0, 1'b0, 1'b0, rd);
    chk("ready_in_reset", {31'd0, rd}, 0);
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, rd);
    chk("reset_desp", {16'd0, desp}, {16'd0, NOPV});
    chk("reset_empty", {31'd0, empty}, 1);

    foreach (tbl[k]) begin
      apply(1'b0, 1'b0, tbl[k].v, tbl[k].ins, tbl[k].p, tbl[k].pr, tbl[k].pq, rd);
      chk($sformatf("tbl%0d_ready", k), {31'd0, rd}, {31'd0, tbl[k].e_ready});
      chk($sformatf("tbl%0d_desp", k), {16'd0, desp}, {16'd0, tbl[k].e_desp});
      chk($sformatf("tbl%0d_valid", k), {31'd0, dv}, {31'd0, tbl[k].e_dv});
      chk($sformatf("tbl%0d_tipo", k), {31'd0, tipo}, {31'd0, tbl[k].e_tipo});
      chk($sformatf("tbl%0d_count", k), {29'd0, cnt}, tbl[k].e_cnt);
    end

    // R cap of 2: third back-to-back ADD is refused, LD still accepted
    apply(1'b0, 1'b0, 1'b1, 16'h4101, 1'b0, 1'b0, 1'b0, rd);
    apply(1'b0, 1'b0, 1'b1, 16'h4102, 1'b0, 1'b0, 1'b0, rd);
    apply(1'b0, 1'b0, 1'b1, 16'h4103, 1'b0, 1'b0, 1'b0, rd);
    chk("maxr_third_ready", {31'd0, rd}, 0);
    chk("maxr_count_r", {29'd0, cnt_r}, 2);
    apply(1'b0, 1'b0, 1'b1, 16'h8104, 1'b0, 1'b0, 1'b0, rd);
    chk("maxr_ld_ready", {31'd0, rd}, 1);
    chk("maxr_count_i", {29'd0, cnt_i}, 1);
    apply(1'b0, 1'b0, 1'b1, 16'hA105, 1'b0, 1'b0, 1'b0, rd);
    chk("fill_full", {31'd0, full}, 1);
    // Full: push refused even with a same-cycle Pop
    apply(1'b0, 1'b0, 1'b1, 16'h8106, 1'b1, 1'b0, 1'b0, rd);
    chk("full_push_ready", {31'd0, rd}, 0);
    chk("full_pop_count", {29'd0, cnt}, 3);
    chk("full_pop_data", {16'd0, desp}, 32'h4101);
    // Ten push/pop pairs wrapping the pointers; pushed class follows the head
    for (int i = 0; i < 10; i++) begin
      ins = (mq[0][16] ? 16'h8000 : 16'h4000) | 16'(i + 16'h0200);
      apply(1'b0, 1'b0, 1'b1, ins, 1'b1, 1'b0, 1'b0, rd);
      chk($sformatf("wrap%0d_ready", i), {31'd0, rd}, 1);
      chk($sformatf("wrap%0d_count", i), {29'd0, cnt}, 3);
    end
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, rd);
    chk("drain_empty", {31'd0, empty}, 1);

    // Unmapped opcode 7
    apply(1'b0, 1'b0, 1'b1, 16'hE077, 1'b0, 1'b0, 1'b0, rd);
    chk("illegal_ready", {31'd0, rd}, 1);
    chk("illegal_pulse", {31'd0, ill}, 1);
    chk("illegal_count", {29'd0, cnt}, 0);
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, rd);
    chk("illegal_pulse_end", {31'd0, ill}, 0);

    // Flush, then Reset, with 3 entries plus a same-cycle push and pop
    for (int rep = 0; rep < 2; rep++) begin
      apply(1'b0, 1'b0, 1'b1, 16'h4301, 1'b0, 1'b0, 1'b0, rd);
      apply(1'b0, 1'b0, 1'b1, 16'h8302, 1'b0, 1'b0, 1'b0, rd);
      apply(1'b0, 1'b0, 1'b1, 16'hA303, 1'b0, 1'b0, 1'b0, rd);
      apply(rep == 1, rep == 0, 1'b1, 16'h4304, 1'b1, 1'b0, 1'b0, rd);
      chk($sformatf("clr%0d_ready", rep), {31'd0, rd}, 0);
      chk($sformatf("clr%0d_count", rep), {29'd0, cnt}, 0);
      chk($sformatf("clr%0d_empty", rep), {31'd0, empty}, 1);
      chk($sformatf("clr%0d_valid", rep), {31'd0, dv}, 0);
      apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, rd);
      chk($sformatf("clr%0d_nothing", rep), {31'd0, dv}, 0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 7, 16'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fila_de_instrucoes_param.md
# fila_de_instrucoes_param

Parametrised in-order instruction queue between the fetch stage and the R/I issue stations. It accepts instructions through a valid/ready push port, tags each with its class (R or I) from a configurable opcode-to-class mask, and dispatches strictly in arrival order. Dispatch can be unconditional or class-filtered. Relative to the fixed 16-bit/8+8 queue, it adds generic width and depth, per-class occupancy caps, flush, illegal-opcode reporting and a registered dispatch-valid handshake.

## Interface
- WIDTH, 16: instruction width in bits.
- DEPTH, 16: total entries; power of two, at least 2.
- OPC_MSB, 15: opcode field MSB; the opcode field is OPC_MSB down to OPC_MSB-2.
- R_MASK, 8'b0000_1100: bit k set means opcode k is class R (ADD=2, SUB=3).
- I_MASK, 8'b0011_0000: bit k set means opcode k is class I (LD=4, ST=5). It must not overlap R_MASK.
- MAX_R, DEPTH: maximum R entries resident at once.
- MAX_I, DEPTH: maximum I entries resident at once.
- NOP, 16'h0005: value driven on the dispatch output when nothing is dispatched.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Flush  in  1  empties the queue at the next edge.
- Push_Valid  in  1  fetch offers Push_Instr.
- Push_Instr  in  WIDTH  offered instruction.
- Push_Ready  out  1  combinational; the push is accepted when Push_Valid and Push_Ready are both high at the edge.
- Pop  in  1  dispatch the head regardless of class.
- Pop_R  in  1  dispatch the head only if it is class R.
- Pop_I  in  1  dispatch the head only if it is class I.
- Instrucao_Despachada  out  WIDTH  registered dispatched instruction.
- Despacho_Valid  out  1  registered; high in the cycle Instrucao_Despachada is a real dispatch.
- Tipo_Despachado  out  1  registered class of the dispatch (0 = R, 1 = I); 0 when not valid.
- Head_Tipo  out  1  class of the current head entry; 0 when empty.
- Illegal  out  1  registered one-cycle pulse when an accepted push carried an unmapped opcode.
- Count  out  $clog2(DEPTH)+1  total occupancy.
- Count_R  out  $clog2(DEPTH)+1  R-class occupancy.
- Count_I  out  $clog2(DEPTH)+1  I-class occupancy.
- Full  out  1  combinational: Count == DEPTH.
- Empty  out  1  combinational: Count == 0.

## Operation
- Storage is one circular buffer of DEPTH entries, each holding {class bit, WIDTH-bit instruction}. Head and tail pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Class decode: opc = Push_Instr[OPC_MSB:OPC_MSB-2].
  - R if R_MASK[opc] is set.
  - I if I_MASK[opc] is set.
  - Otherwise the opcode is illegal.
- Push_Ready is high when all of the following hold:
  - Reset and Flush are low;
  - the queue is not Full;
  - for an R opcode, Count_R < MAX_R; for an I opcode, Count_I < MAX_I.
  - For an illegal opcode, Push_Ready is high (subject to Reset and Flush low); the word is consumed but not stored, and Illegal pulses.
- Dispatch select, evaluated on the current head, highest priority first:
  - Flush.
  - Pop with !Empty.
  - Pop_R with !Empty and head class R.
  - Pop_I with !Empty and head class I.
  - No request matches: no dispatch.
- On dispatch at an edge: Instrucao_Despachada, Despacho_Valid and Tipo_Despachado are loaded; head advances; Count and the class count decrement.
- Without a dispatch: Instrucao_Despachada = NOP, Despacho_Valid = 0, Tipo_Despachado = 0.
- Simultaneous push and dispatch in one cycle:
  - Both take effect; Count is unchanged.
  - Class counts move independently (e.g. push I plus pop R gives Count_I+1, Count_R-1).
  - Readiness is computed on pre-edge state, so a push is refused when the queue is Full even if a pop occurs in the same cycle.
- No bypass: an entry pushed into an empty queue is dispatchable at the following edge at the earliest.
- Flush:
  - Pointers and all counts go to 0.
  - Outputs take their NOP/idle values.
  - Any same-cycle push or pop is ignored.
- Reset has the same effect as Flush and takes priority over everything. Entry contents are don't-care after Reset or Flush.

## Timing
- Reset values: Instrucao_Despachada = NOP, Despacho_Valid = 0, Tipo_Despachado = 0, Illegal = 0, Count = Count_R = Count_I = 0, Empty = 1, Full = 0, Head_Tipo = 0, Push_Ready = 0 while Reset is high.
- Pop-to-output latency: 1 cycle. A Pop sampled at edge n appears on the outputs after edge n and is held for exactly one cycle.
- Full, Empty, Count and Head_Tipo reflect state after the last edge; there is no combinational path from Pop.
- Push_Ready depends combinationally on Push_Instr, Flush, Reset and internal state only; it never depends on Pop.
- Wrap-around: after DEPTH pushes and pops the pointers return to 0 with no bubble.
- Sustained throughput: 1 push plus 1 dispatch per cycle.

## Test plan
- Reset, then push ADD, LD, SUB, ST and issue Pop ×4. Dispatch order is ADD, LD, SUB, ST with Tipo 0,1,0,1. Despacho_Valid is high for 4 cycles, then Empty = 1 and the output is 16'h0005.
- Head = LD, assert Pop_R. Result: no dispatch, Despacho_Valid = 0, Count unchanged. Then assert Pop_I: LD is dispatched with Tipo_Despachado = 1.
- MAX_R = 2, push ADD ×3 back-to-back. The third cycle has Push_Ready = 0 and ends with Count_R = 2. Pushing LD in the next cycle is accepted (Count_I = 1).
- DEPTH = 4: fill to Full, then drive Push_Valid with Pop in the same cycle. The push is refused and Count goes 4→3. Run 10 push/pop pairs so the pointers wrap; all data returns in order.
- Push opcode 7 (unmapped). Result: Push_Ready = 1, Illegal pulses for 1 cycle, Count is unchanged.
- With 3 entries, assert Flush together with Push_Valid and Pop. Next cycle: Count = 0, Empty = 1, Despacho_Valid = 0, nothing stored. Repeat the scenario with Reset in place of Flush: same result.
